// File: rtl/vga_sprite_fetch_if.sv
// Read-only port into video-shared memory.
// Master issues address/strobe; data returns a fixed latency later.
interface vga_sprite_fetch_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_data;

    modport master (
        output mem_addr,
        output mem_rd,
        input  mem_data
    );

    modport slave (
        input  mem_addr,
        input  mem_rd,
        output mem_data
    );
endinterface

// File: rtl/vga_sprite_fetch.sv
// Per-frame sprite coordinate fetch into shadow registers,
// committed to the renderer-facing outputs in a single cycle.
module vga_sprite_fetch #(
    parameter int NUM_SPRITES = 3,
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int BASE_ADDR   = 0,
    parameter int X_OFFSET    = 32,
    parameter int MEM_LAT     = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          clr_overrun,
    vga_sprite_fetch_if.master            mem,
    output logic [NUM_SPRITES*DATA_W-1:0] sprite_x,
    output logic [NUM_SPRITES*DATA_W-1:0] sprite_y,
    output logic [DATA_W-1:0]             cont,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          overrun
);

    localparam int W     = 2*NUM_SPRITES + 1;
    localparam int IDX_W = $clog2(W + 1);
    localparam int SW    = NUM_SPRITES*DATA_W;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        COMMIT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [IDX_W-1:0]  idx;
    logic [MEM_LAT-1:0] pv;
    logic [IDX_W-1:0]  pidx [MEM_LAT];
    logic              cap_v;
    logic [IDX_W-1:0]  cap_idx;
    logic              last_cap;

    logic [SW-1:0]     shadow_x;
    logic [SW-1:0]     shadow_y;
    logic [DATA_W-1:0] shadow_cont;

    assign cap_v    = pv[MEM_LAT-1];
    assign cap_idx  = pidx[MEM_LAT-1];
    assign last_cap = cap_v && (cap_idx == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        mem.mem_rd   = 1'b0;
        mem.mem_addr = '0;
        busy         = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = FETCH;
            end
            FETCH: begin
                mem.mem_rd   = 1'b1;
                mem.mem_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(idx);
                if (idx == LAST) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (last_cap) state_nxt = COMMIT;
            end
            COMMIT: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx <= '0;
        end else if (state == FETCH) begin
            idx <= idx + IDX_W'(1);
        end else begin
            idx <= '0;
        end
    end

    // {valid, idx} travels with each read so the capture knows its slot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pv <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                pidx[i] <= '0;
            end
        end else begin
            pv[0]   <= (state == FETCH);
            pidx[0] <= idx;
            for (int i = 1; i < MEM_LAT; i++) begin
                pv[i]   <= pv[i-1];
                pidx[i] <= pidx[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_x    <= '0;
            shadow_y    <= '0;
            shadow_cont <= '0;
        end else if (cap_v) begin
            if (cap_idx == LAST) begin
                shadow_cont <= mem.mem_data;
            end
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (cap_idx == IDX_W'(2*i)) begin
                    shadow_x[i*DATA_W +: DATA_W] <=
                        mem.mem_data - DATA_W'(X_OFFSET);
                end
                if (cap_idx == IDX_W'(2*i + 1)) begin
                    shadow_y[i*DATA_W +: DATA_W] <= mem.mem_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sprite_x   <= '0;
            sprite_y   <= '0;
            cont       <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state == COMMIT);
            if (state == COMMIT) begin
                sprite_x <= shadow_x;
                sprite_y <= shadow_y;
                cont     <= shadow_cont;
            end
        end
    end

    // a fresh overrun event outranks a clear in the same cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (start && busy) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

endmodule
